// File: rtl/pontuacao_pkg.sv
// -----------------------------------------------------------------------------
// pontuacao_pkg
// Shared types and constants for the round controller and its error counter.
//   estado_t      : round controller state encoding (3-bit)
//   ROD_W         : width of the round index
//   ERR_W         : width of the per-round error count
//   PTS_W         : width of the running score
//   PTS_MAX       : saturated score value
//   satura_pontos : score capture that never lets the running score go down
// -----------------------------------------------------------------------------
package pontuacao_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    JOGANDO = 3'd1,
    CALCULA = 3'd2,
    CAPTURA = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam int ROD_W = 4;
  localparam int ERR_W = 8;
  localparam int PTS_W = 8;

  localparam logic [PTS_W-1:0] PTS_MAX = 8'hFF;

  // A calculator result below the current score means its 8-bit sum wrapped;
  // pin the score at the maximum instead of letting it fall.
  function automatic logic [PTS_W-1:0] satura_pontos(input logic [PTS_W-1:0] novo,
                                                     input logic [PTS_W-1:0] atual);
    return (novo < atual) ? PTS_MAX : novo;
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// -----------------------------------------------------------------------------
// contador_saturado
// Up-counter with synchronous clear that sticks at all-ones.
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-low reset
//   limpar      in   synchronous clear (wins over incrementar)
//   incrementar in   count enable
//   valor       out  registered count
//   valor_inc   out  saturated value+1, available combinationally so the
//                    parent can act on the count it is about to load
// -----------------------------------------------------------------------------
module contador_saturado #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpar,
  input  logic         incrementar,
  output logic [W-1:0] valor,
  output logic [W-1:0] valor_inc
);

  logic [W-1:0] valor_q;
  logic [W-1:0] valor_d;

  assign valor_inc = (&valor_q) ? valor_q : valor_q + W'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a path
    // that does not assign it infers a latch.
    valor_d = valor_q;
    if (limpar) begin
      valor_d = '0;
    end else if (incrementar) begin
      valor_d = valor_inc;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; the reset is sampled on the edge like any other input.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign valor = valor_q;

endmodule

// File: rtl/controle_rodada.sv
// -----------------------------------------------------------------------------
// controle_rodada
// Round controller upstream of the score calculator. Counts rounds and errors,
// strobes the calculator at each round end and captures its result into the
// running score that feeds back into the calculator.
//
// Parameters:
//   MAX_ERROS   errors in one round that end the game (1..255)
//   NUM_RODADAS rounds in a full game (1..16)
// Ports:
//   clock, reset       rising-edge clock, synchronous active-low reset
//   iniciar            start/restart pulse (honoured in OCIOSO and FIM)
//   jogada_errada      one pulse per wrong player input
//   fim_rodada         player finished the round's sequence
//   pontos_calc        calculator result, sampled one cycle after the strobe
//   rodada             current round index, 0-based
//   erros              errors in the current round
//   calcular_pontos    one-cycle calculator strobe
//   pontos_acumulados  running score
//   jogando/fim_jogo/vitoria  status decoded from registered state
// Configuration:
//   CONTROLE_RODADA_SATURA_EN  when defined, a captured score lower than the
//                              current one (calculator wrap) saturates to 8'hFF
// -----------------------------------------------------------------------------
module controle_rodada
  import pontuacao_pkg::*;
#(
  parameter int MAX_ERROS   = 3,
  parameter int NUM_RODADAS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             jogada_errada,
  input  logic             fim_rodada,
  input  logic [PTS_W-1:0] pontos_calc,
  output logic [ROD_W-1:0] rodada,
  output logic [ERR_W-1:0] erros,
  output logic             calcular_pontos,
  output logic [PTS_W-1:0] pontos_acumulados,
  output logic             jogando,
  output logic             fim_jogo,
  output logic             vitoria
);

  localparam logic [ERR_W-1:0] LIMITE  = ERR_W'(MAX_ERROS);
  localparam logic [ROD_W-1:0] ULTIMA  = ROD_W'(NUM_RODADAS - 1);

  estado_t          estado_q, estado_d;
  logic [ROD_W-1:0] rodada_q, rodada_d;
  logic [PTS_W-1:0] pontos_q, pontos_d;
  logic             calc_q, calc_d;
  logic             venceu_q, venceu_d;

  logic             erros_limpar;
  logic             erros_incrementar;
  logic [ERR_W-1:0] erros_inc;
  logic [PTS_W-1:0] pontos_capturados;

  contador_saturado #(
    .W (ERR_W)
  ) u_erros (
    .clock       (clock),
    .reset       (reset),
    .limpar      (erros_limpar),
    .incrementar (erros_incrementar),
    .valor       (erros),
    .valor_inc   (erros_inc)
  );

`ifdef CONTROLE_RODADA_SATURA_EN
  assign pontos_capturados = satura_pontos(pontos_calc, pontos_q);
`else
  assign pontos_capturados = pontos_calc;
`endif

  always_comb begin
    estado_d          = estado_q;
    rodada_d          = rodada_q;
    pontos_d          = pontos_q;
    venceu_d          = venceu_q;
    erros_limpar      = 1'b0;
    erros_incrementar = 1'b0;

    unique case (estado_q)
      OCIOSO: begin
        rodada_d     = '0;
        pontos_d     = '0;
        venceu_d     = 1'b0;
        erros_limpar = 1'b1;
        if (iniciar) estado_d = JOGANDO;
      end

      JOGANDO: begin
        erros_incrementar = jogada_errada;
        // The error is counted before the round end is considered, so a
        // simultaneous limit-reaching error forfeits the round's points.
        if (jogada_errada && (erros_inc == LIMITE)) begin
          estado_d = FIM;
          venceu_d = 1'b0;
        end else if (fim_rodada) begin
          estado_d = CALCULA;
        end
      end

      CALCULA: estado_d = CAPTURA;

      CAPTURA: begin
        pontos_d = pontos_capturados;
        if (rodada_q == ULTIMA) begin
          estado_d = FIM;
          venceu_d = 1'b1;
        end else begin
          rodada_d     = rodada_q + ROD_W'(1);
          erros_limpar = 1'b1;
          estado_d     = JOGANDO;
        end
      end

      FIM: begin
        if (iniciar) begin
          rodada_d     = '0;
          pontos_d     = '0;
          venceu_d     = 1'b0;
          erros_limpar = 1'b1;
          estado_d     = JOGANDO;
        end
      end

      default: estado_d = OCIOSO;
    endcase

    // Strobe is registered alongside the state, so it is high exactly for
    // the cycle spent in CALCULA.
    calc_d = (estado_d == CALCULA);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      rodada_q <= '0;
      pontos_q <= '0;
      calc_q   <= 1'b0;
      venceu_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      rodada_q <= rodada_d;
      pontos_q <= pontos_d;
      calc_q   <= calc_d;
      venceu_q <= venceu_d;
    end
  end

  assign rodada            = rodada_q;
  assign pontos_acumulados = pontos_q;
  assign calcular_pontos   = calc_q;
  assign jogando           = (estado_q == JOGANDO);
  assign fim_jogo          = (estado_q == FIM);
  assign vitoria           = (estado_q == FIM) && venceu_q;

endmodule

// File: tb/tb_controle_rodada.sv
// -----------------------------------------------------------------------------
// tb_controle_rodada
// Directed scenarios followed by random play, all compared every cycle against
// a game-level reference model; the bench also plays the score calculator.
// -----------------------------------------------------------------------------
module tb_controle_rodada;

  localparam int MAX_ERROS   = 3;
  localparam int NUM_RODADAS = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       jogada_errada = 1'b0;
  logic       fim_rodada = 1'b0;
  logic [7:0] pontos_calc = 8'h00;
  logic [3:0] rodada;
  logic [7:0] erros;
  logic       calcular_pontos;
  logic [7:0] pontos_acumulados;
  logic       jogando;
  logic       fim_jogo;
  logic       vitoria;

  int n_checks = 0;
  int n_errors = 0;

  controle_rodada #(
    .MAX_ERROS   (MAX_ERROS),
    .NUM_RODADAS (NUM_RODADAS)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .iniciar           (iniciar),
    .jogada_errada     (jogada_errada),
    .fim_rodada        (fim_rodada),
    .pontos_calc       (pontos_calc),
    .rodada            (rodada),
    .erros             (erros),
    .calcular_pontos   (calcular_pontos),
    .pontos_acumulados (pontos_acumulados),
    .jogando           (jogando),
    .fim_jogo          (fim_jogo),
    .vitoria           (vitoria)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model: game phase plus counters, advanced once per rising edge.
  // ---------------------------------------------------------------------------
  localparam int P_IDLE   = 0;  // waiting for start
  localparam int P_PLAY   = 1;  // player is playing a round
  localparam int P_STROBE = 2;  // round ended, calculator being asked
  localparam int P_TAKE   = 3;  // calculator answer being taken
  localparam int P_OVER   = 4;  // game over

  int m_phase = P_IDLE;
  int m_round = 0;
  int m_err   = 0;
  int m_score = 0;
  int m_win   = 0;

  function automatic int new_score(input int pc, input int cur);
`ifdef CONTROLE_RODADA_SATURA_EN
    if (pc < cur) return 255;
`endif
    return pc;
  endfunction

  task automatic model_edge(input logic ini, input logic err, input logic fr,
                            input logic rst_n_v, input int pc);
    if (!rst_n_v) begin
      m_phase = P_IDLE; m_round = 0; m_err = 0; m_score = 0; m_win = 0;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        m_round = 0; m_err = 0; m_score = 0; m_win = 0;
        if (ini) m_phase = P_PLAY;
      end
      P_PLAY: begin
        if (err) begin
          m_err = (m_err == 255) ? 255 : m_err + 1;
          if (m_err == MAX_ERROS) begin
            m_phase = P_OVER; m_win = 0;
            return;
          end
        end
        if (fr) m_phase = P_STROBE;
      end
      P_STROBE: m_phase = P_TAKE;
      P_TAKE: begin
        m_score = new_score(pc, m_score);
        if (m_round == NUM_RODADAS - 1) begin
          m_phase = P_OVER; m_win = 1;
        end else begin
          m_round++; m_err = 0; m_phase = P_PLAY;
        end
      end
      default: begin
        if (ini) begin
          m_round = 0; m_err = 0; m_score = 0; m_win = 0; m_phase = P_PLAY;
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("rodada",            32'(rodada),            32'(m_round));
    check("erros",             32'(erros),             32'(m_err));
    check("calcular_pontos",   32'(calcular_pontos),   32'(m_phase == P_STROBE));
    check("pontos_acumulados", 32'(pontos_acumulados), 32'(m_score));
    check("jogando",           32'(jogando),           32'(m_phase == P_PLAY));
    check("fim_jogo",          32'(fim_jogo),          32'(m_phase == P_OVER));
    check("vitoria",           32'(vitoria),           32'(m_phase == P_OVER && m_win == 1));
  endtask

  // One clock cycle: drive, let the edge happen, sample on the falling edge.
  task automatic step(input logic ini, input logic err, input logic fr, input logic rst_n_v);
    iniciar       = ini;
    jogada_errada = err;
    fim_rodada    = fr;
    reset         = rst_n_v;
    @(posedge clock);
    model_edge(ini, err, fr, rst_n_v, int'(pontos_calc));
    @(negedge clock);
    compare_all();
    iniciar       = 1'b0;
    jogada_errada = 1'b0;
    fim_rodada    = 1'b0;
    reset         = 1'b1;
  endtask

  task automatic clean_round(input logic [7:0] pc);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    pontos_calc = pc;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_jogando", 32'(jogando), 32'd0);

    // First round, calculator returns 5.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("strobe_after_fim_rodada", 32'(calcular_pontos), 32'd1);
    pontos_calc = 8'h05;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("strobe_one_cycle", 32'(calcular_pontos), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("first_score", 32'(pontos_acumulados), 32'h05);
    check("first_rodada", 32'(rodada), 32'd1);

    // Round 1 clean, then three errors in round 2.
    clean_round(8'h09);
    check("round2", 32'(rodada), 32'd2);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("erros_count", 32'(erros), 32'(i));
    end
    check("limit_fim_jogo", 32'(fim_jogo), 32'd1);
    check("limit_vitoria", 32'(vitoria), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("limit_no_strobe", 32'(calcular_pontos), 32'd0);

    // Restart from FIM clears the score.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("restart_score", 32'(pontos_acumulados), 32'd0);
    check("restart_jogando", 32'(jogando), 32'd1);

    // Simultaneous error and round end below the limit.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("simul_erros", 32'(erros), 32'd2);
    check("simul_strobe", 32'(calcular_pontos), 32'd1);
    pontos_calc = 8'h11;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // Simultaneous error and round end hitting the limit.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("simul_limit_fim", 32'(fim_jogo), 32'd1);
    check("simul_limit_no_strobe", 32'(calcular_pontos), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Full clean game.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < NUM_RODADAS; r++) clean_round(8'($urandom));
    check("victory", 32'(vitoria), 32'd1);
    check("victory_rodada", 32'(rodada), 32'd15);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("victory_hold_rodada", 32'(rodada), 32'd15);

    // Score wrap handling.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    clean_round(8'hF0);
    check("score_f0", 32'(pontos_acumulados), 32'hF0);
    clean_round(8'h04);
`ifdef CONTROLE_RODADA_SATURA_EN
    check("score_wrap", 32'(pontos_acumulados), 32'hFF);
`else
    check("score_wrap", 32'(pontos_acumulados), 32'h04);
`endif

    // Reset during CALCULA.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_strobe", 32'(calcular_pontos), 32'd0);
    check("abort_score", 32'(pontos_acumulados), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // iniciar ignored while playing.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("iniciar_ignored", 32'(erros), 32'd1);

    // Random play against the model.
    for (int c = 0; c < 3000; c++) begin
      pontos_calc = 8'($urandom);
      step($urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 299) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controle_rodada.md
# controle_rodada

Round controller that sits directly upstream of the score calculator in the game datapath. Tracks the current round and the player's errors in that round. At each round end it issues a one-cycle `calcular_pontos` strobe and captures the calculator's result into the running score register. That register is fed back to the calculator as its score input. It also detects game over (error limit reached) and victory (last round completed).

## Interface
Parameters:
- `MAX_ERROS`, default 3: number of errors within one round that ends the game; legal range 1..255.
- `NUM_RODADAS`, default 16: number of rounds in a full game; legal range 1..16.

Ports:
- `clock`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `iniciar`  in  1  start/restart pulse.
- `jogada_errada`  in  1  one-cycle pulse per wrong player input.
- `fim_rodada`  in  1  one-cycle pulse: player completed the round's sequence.
- `pontos_calc`  in  8  score result from the calculator; valid one cycle after `calcular_pontos`.
- `rodada`  out  4  current round index, 0-based; drives the calculator's round input.
- `erros`  out  8  errors in the current round; drives the calculator's error input.
- `calcular_pontos`  out  1  one-cycle strobe to the calculator.
- `pontos_acumulados`  out  8  running score; drives the calculator's score input.
- `jogando`  out  1  high in JOGANDO.
- `fim_jogo`  out  1  high in FIM.
- `vitoria`  out  1  high in FIM when all rounds were completed.

## Operation
- States: OCIOSO, JOGANDO, CALCULA, CAPTURA, FIM.
- OCIOSO:
  - `iniciar` → JOGANDO.
  - Clears `rodada`, `erros`, `pontos_acumulados` and `vitoria`.
- JOGANDO:
  - `jogada_errada` increments `erros`, saturating at 8'hFF.
  - If the incremented value equals `MAX_ERROS` → FIM with `vitoria`=0; no points for that round.
  - Otherwise, if `fim_rodada` is set → CALCULA.
  - Simultaneous `jogada_errada` and `fim_rodada`: the error is counted first. The limit check wins; otherwise go to CALCULA with the updated `erros`.
  - `iniciar` is ignored.
- CALCULA: `calcular_pontos`=1 for exactly this cycle → CAPTURA.
- CAPTURA:
  - `pontos_acumulados` <= `pontos_calc`, filtered as described in Configuration.
  - If `rodada` == `NUM_RODADAS`-1 → FIM with `vitoria`=1.
  - Otherwise `rodada`++, `erros`<=0 → JOGANDO.
- FIM:
  - Outputs are held.
  - `iniciar` → JOGANDO with the same clears as OCIOSO.
- Inputs `jogada_errada`, `fim_rodada` and `iniciar` are ignored in CALCULA and CAPTURA; they are not queued.
- `rodada` never wraps; its maximum is `NUM_RODADAS`-1.

## Timing
- Reset values:
  - state OCIOSO;
  - `rodada`=0, `erros`=0, `pontos_acumulados`=0;
  - `calcular_pontos`=0, `jogando`=0, `fim_jogo`=0, `vitoria`=0.
- `reset` low in any state, including mid-CALCULA or mid-CAPTURA, aborts everything in the same edge; no strobe is emitted afterwards.
- `fim_rodada` at edge N: `calcular_pontos` is high during cycle N+1.
- `pontos_calc` is sampled at edge N+2. The calculator's output must be settled one cycle after the strobe.
- At edge N+2 the round advances and `erros` clears.
- `jogada_errada` at edge N: `erros` updates at N+1, and `fim_jogo` rises at N+1 when the limit is reached.
- `rodada`, `erros` and `pontos_acumulados` are registered and stable from the strobe cycle through the capture edge.
- All outputs are registered except `jogando`, `fim_jogo` and `vitoria`, which decode directly from registered state.

## Configuration
- Macro: `CONTROLE_RODADA_SATURA_EN`.
- Defined: in CAPTURA, if `pontos_calc` < `pontos_acumulados` (calculator wrapped), `pontos_acumulados` <= 8'hFF. The score saturates and never decreases.
- Undefined: `pontos_calc` is captured unmodified.

## Structure
- Package `pontuacao_pkg`:
  - state enum (3-bit);
  - widths `ROD_W`=4, `ERR_W`=8, `PTS_W`=8;
  - constant `PTS_MAX`=8'hFF.
- Sub-module `contador_saturado`:
  - parameterised width;
  - synchronous clear, increment enable, saturate at all-ones;
  - used for `erros`.
- The round counter and the score register are inline.

## Test plan
- Reset then `iniciar`, `fim_rodada` with 0 errors, bench calculator returns 8'h05 → `calcular_pontos` high exactly one cycle after `fim_rodada`; `pontos_acumulados`=5, `rodada`=1, `erros`=0 two cycles after `fim_rodada`.
- Default `MAX_ERROS`=3, three `jogada_errada` pulses in round 2 → `erros` 1,2,3; `fim_jogo`=1, `vitoria`=0, no `calcular_pontos` strobe.
- `jogada_errada` and `fim_rodada` in the same cycle with `erros`=1 → `erros`=2, strobe issued. With `erros`=2 → FIM instead, no strobe.
- Play 16 clean rounds → `vitoria`=1 after the 16th capture, `rodada` stays 15.
- `pontos_acumulados`=8'hF0 and `pontos_calc`=8'h04 → with the macro defined, 8'hFF; without it, 8'h04.
- `reset` low during CALCULA → next cycle OCIOSO, all outputs 0. `iniciar` during JOGANDO → no effect. `iniciar` in FIM → JOGANDO with score 0.
